// File: rtl/dat_write_crc_status_if.sv
// dat_write_crc_status_if: DAT0 line, start/abort controls and token/busy result bundle.
interface dat_write_crc_status_if;
    logic       start_i;
    logic       abort_i;
    logic       dat0_i;
    logic       busy_o;
    logic       done_o;
    logic [2:0] status_o;
    logic       crc_ok_o;
    logic       crc_err_o;
    logic       write_err_o;
    logic       token_err_o;
    logic       timeout_err_o;
    modport master (
        output start_i, abort_i, dat0_i,
        input  busy_o, done_o, status_o, crc_ok_o, crc_err_o, write_err_o, token_err_o, timeout_err_o
    );
    modport slave (
        input  start_i, abort_i, dat0_i,
        output busy_o, done_o, status_o, crc_ok_o, crc_err_o, write_err_o, token_err_o, timeout_err_o
    );
endinterface

// File: rtl/dat_write_crc_status.sv
// dat_write_crc_status: captures the SD CRC status token on DAT0, then tracks card busy until release or timeout.
module dat_write_crc_status #(
    parameter int StartTimeout = 8,
    parameter int BusyTimeout  = 65535,
    parameter int BusyCntWidth = 16
) (
    input logic                   sd_clk_i,
    input logic                   rst_i,
    dat_write_crc_status_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_START, STATUS, END_BIT, BUSY} state_t;
    localparam logic [BusyCntWidth-1:0] StartLast = BusyCntWidth'(StartTimeout - 1);
    localparam logic [BusyCntWidth-1:0] BusyLast  = BusyCntWidth'(BusyTimeout - 1);
    localparam logic [BusyCntWidth-1:0] GuardEnd  = BusyCntWidth'(2);
    localparam logic [BusyCntWidth-1:0] LastBit   = BusyCntWidth'(2);
    state_t                  state_q, state_d;
    logic [BusyCntWidth-1:0] cnt_q, cnt_d;
    logic [2:0]              status_q, status_d;
    logic [4:0]              flags_q, flags_d; // {crc_ok, crc_err, write_err, token_err, timeout}
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    is_ok, is_crc, is_wr;
    assign is_ok  = status_q == 3'b010;
    assign is_crc = status_q == 3'b101;
    assign is_wr  = status_q == 3'b110;
    always_comb begin
        state_d  = state_q;
        cnt_d    = (&cnt_q) ? cnt_q : cnt_q + BusyCntWidth'(1);
        status_d = status_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d  = WAIT_START;
                    cnt_d    = '0;
                    status_d = '0;
                    flags_d  = '0;
                end
            end
            WAIT_START: begin
                if (!bus.dat0_i) begin
                    state_d = STATUS;
                    cnt_d   = '0;
                end else if (cnt_q >= StartLast) begin
                    state_d    = IDLE;
                    flags_d[0] = 1'b1;
                    done_d     = 1'b1;
                end
            end
            STATUS: begin
                status_d = {status_q[1:0], bus.dat0_i};
                state_d  = cnt_q == LastBit ? END_BIT : STATUS;
            end
            END_BIT: begin
                // A low end bit means the token is unusable, so busy is not tracked.
                if (!bus.dat0_i) begin
                    state_d    = IDLE;
                    flags_d[1] = 1'b1;
                    done_d     = 1'b1;
                end else begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    flags_d = {is_ok, is_crc, is_wr, !(is_ok || is_crc || is_wr), 1'b0};
                end
            end
            BUSY: begin
                if (cnt_q >= GuardEnd && bus.dat0_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q >= BusyLast) begin
                    state_d    = IDLE;
                    flags_d[0] = 1'b1;
                    done_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            flags_d = '0;
            done_d  = 1'b0;
        end
        busy_d = state_d == STATUS || state_d == END_BIT || state_d == BUSY;
    end
    always_ff @(posedge sd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            status_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.status_o      = status_q;
    assign bus.crc_ok_o      = flags_q[4];
    assign bus.crc_err_o     = flags_q[3];
    assign bus.write_err_o   = flags_q[2];
    assign bus.token_err_o   = flags_q[1];
    assign bus.timeout_err_o = flags_q[0];
endmodule

// File: tb/tb_dat_write_crc_status.sv
// tb_dat_write_crc_status: directed token/busy vectors, expected done cycle and flags queued and checked by a monitor.
module tb_dat_write_crc_status;
    typedef struct {
        int         cyc;
        logic [7:0] res;
    } exp_t;
    logic clk, rst;
    int   cyc;
    int   vectors, miscompares;
    exp_t exp_q[$];
    dat_write_crc_status_if bus();
    dat_write_crc_status #(.StartTimeout(8), .BusyTimeout(20), .BusyCntWidth(16)) dut (
        .sd_clk_i(clk),
        .rst_i   (rst),
        .bus     (bus.slave)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    function automatic logic [7:0] res_now();
        return {bus.status_o, bus.crc_ok_o, bus.crc_err_o, bus.write_err_o, bus.token_err_o, bus.timeout_err_o};
    endfunction
    function automatic void chk(string n, int act, int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", n, act, want, cyc);
        end
    endfunction
    always @(negedge clk) begin
        if (!rst && bus.done_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_result", int'(res_now()), int'(e.res));
                chk("done_busy_low", int'(bus.busy_o), 0);
            end
        end
    end
    // w: cycles DAT0 stays high before the start bit; low: busy cycles held low; rs: offset of a stray start_i
    task automatic run(input string n, input int w, input logic [2:0] tok, input logic endb,
                       input int low, input int len, input int rs, input int off, input logic [7:0] res);
        exp_t e;
        e.cyc = cyc + 1 + off;
        e.res = res;
        exp_q.push_back(e);
        bus.start_i = 1'b1;
        bus.dat0_i  = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= len; i++) begin
            bus.start_i = i == rs;
            bus.dat0_i  = i <= w ? 1'b1 : i == w + 1 ? 1'b0 : i <= w + 4 ? tok[w + 4 - i] :
                          i == w + 5 ? endb : i <= w + 5 + low ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        bus.dat0_i  = 1'b1;
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk({n, "_no_done"}, exp_q.size(), 0);
            exp_q.delete();
        end
        chk({n, "_sticky"}, int'(res_now()), int'(res));
    endtask
    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.dat0_i  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_res", int'(res_now()), 0);
        chk("reset_busy_done", int'({bus.busy_o, bus.done_o}), 0);
        run("ok_busy5",   1,   3'b010, 1'b1, 5,   12, 9, 12, 8'b010_10000);
        run("crc_err",    1,   3'b101, 1'b1, 0,   9,  0, 9,  8'b101_01000);
        run("start_to",   100, 3'b000, 1'b1, 0,   10, 0, 8,  8'b000_00001);
        run("end_bit0",   1,   3'b010, 1'b0, 0,   6,  0, 6,  8'b010_00010);
        run("busy_to",    1,   3'b010, 1'b1, 100, 30, 0, 26, 8'b010_10001);
        run("write_err",  1,   3'b110, 1'b1, 0,   9,  0, 9,  8'b110_00100);
        run("bad_token",  1,   3'b011, 1'b1, 0,   9,  0, 9,  8'b011_00010);
        run("late_start", 7,   3'b010, 1'b1, 0,   15, 0, 15, 8'b010_10000);
        run("busy_18",    1,   3'b010, 1'b1, 18,  26, 0, 25, 8'b010_10000);
        // abort together with start in IDLE: stays idle, sticky flags cleared
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.dat0_i  = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_idle_busy", int'(bus.busy_o), 0);
        chk("abort_idle_flags", int'(res_now() & 8'h1f), 0);
        bus.dat0_i = 1'b1;
        repeat (2) @(negedge clk);
        // abort mid-STATUS
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.dat0_i  = 1'b1;
        @(negedge clk);
        bus.dat0_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("status_busy", int'(bus.busy_o), 1);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        bus.dat0_i  = 1'b1;
        chk("abort_busy", int'(bus.busy_o), 0);
        repeat (12) @(negedge clk);
        chk("abort_flags", int'(res_now() & 8'h1f), 0);
        // reset while in BUSY clears outputs immediately
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            bus.dat0_i = i == 1 ? 1'b1 : i == 2 ? 1'b0 : i == 3 ? 1'b0 : i == 4 ? 1'b1 : i == 5 ? 1'b0 :
                         i == 6 ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        chk("busy_state", int'(bus.busy_o), 1);
        chk("busy_ok", int'(bus.crc_ok_o), 1);
        rst = 1'b1;
        #1;
        chk("rst_res", int'(res_now()), 0);
        chk("rst_busy_done", int'({bus.busy_o, bus.done_o}), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.dat0_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_idle_busy", int'(bus.busy_o), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
